// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the multi-channel switch debouncer.
//   dbc_state_e    : per-channel qualification state (encoding is fixed so
//                    the state can be decoded directly by software or debug)
//   is_wait_state  : true while a channel is qualifying a change
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } dbc_state_e;

  function automatic logic is_wait_state(input dbc_state_e s);
    return (s == ST_PRESS_WAIT) || (s == ST_RELEASE_WAIT);
  endfunction

  function automatic logic is_level_state(input dbc_state_e s);
    return (s == ST_PRESSED) || (s == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input: 2-flop synchroniser, polarity normalisation,
// qualification FSM with a stability counter, and registered outputs.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | released, waiting for a pressed sample
// PRESS_WAIT   | counting consecutive pressed samples
// PRESSED      | press accepted, waiting for a released sample
// RELEASE_WAIT | counting consecutive released samples
//
// Ports
//   clk             : clock
//   reset           : synchronous, active-high
//   raw_i           : asynchronous raw switch level
//   level_o         : registered debounced level, 1 = pressed
//   press_pulse_o   : one-cycle strobe on accepted press
//   release_pulse_o : one-cycle strobe on accepted release
//   wait_d_o        : next state is a WAIT state (feeds the registered busy)
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int ACTIVE_LOW    = 1,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic wait_d_o
);

  // Synchroniser resets to the raw level that means "not pressed", so a
  // channel never sees a phantom press coming out of reset.
  localparam logic             INACTIVE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             pressed;
  dbc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, press_q, release_q;

  assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!pressed) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (pressed) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so level_o moves on the same
  // edge as the accepting transition, and the strobes line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= INACTIVE_RAW;
      sync2_q   <= INACTIVE_RAW;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= is_level_state(state_d);
      press_q   <= (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);
      release_q <= (state_q == ST_RELEASE_WAIT) && (state_d == ST_IDLE);
    end
  end

  assign level_o         = level_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign wait_d_o        = is_wait_state(state_d);

endmodule

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
// N_CH independent switch debouncers with a shared busy indication.
//
// Ports
//   clk           : clock, all state on rising edge
//   reset         : synchronous, active-high
//   raw_in        : asynchronous bouncing switch inputs
//   level_out     : debounced pressed state per channel, 1 = pressed
//   press_pulse   : one-cycle strobe per channel on accepted press
//   release_pulse : one-cycle strobe per channel on accepted release
//   busy          : registered, high while any channel is qualifying
// -----------------------------------------------------------------------------
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);

  logic [N_CH-1:0] wait_d;
  logic            busy_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .raw_i           (raw_in[g]),
      .level_o         (level_out[g]),
      .press_pulse_o   (press_pulse[g]),
      .release_pulse_o (release_pulse[g]),
      .wait_d_o        (wait_d[g])
    );
  end

  // OR of next-state WAIT flags, registered: busy tracks the channel state
  // registers exactly and is glitch-free at the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= |wait_d;
    end
  end

  assign busy = busy_q;

endmodule
